wb_arbiter2: RTL and testbench
==============================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter AW, default 30, word-address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles without response before an abort (used only with WB_ARB_TIMEOUT_EN).
REQ-004 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_m_cyc, i_m_stb, i_m_we  input  2 each  per-master cycle, strobe and write (bit 0 = master 0).
REQ-007 SHALL have port i_m_addr  input  2*AW  per-master address, master 0 in the low AW bits.
REQ-008 SHALL have port i_m_data  input  2*DW  per-master write data.
REQ-009 SHALL have port i_m_sel  input  8  per-master byte select, 4 bits each.
REQ-010 SHALL have port o_m_ack, o_m_stall, o_m_err  output  2 each  per-master responses.
REQ-011 SHALL have port o_m_data  output  DW  read data, broadcast to both masters.
REQ-012 SHALL have port o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel  output  1/1/1/AW/DW/4  slave-side request.
REQ-013 SHALL have port i_s_ack, i_s_stall, i_s_err, i_s_data  input  1/1/1/DW  slave-side response.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, GNT0 and GNT1.
REQ-015 IDLE: a request is i_m_cyc[n]. If only one master requests, the FSM SHALL move to GNTn on the next edge. If both request, the master not granted last SHALL win; after reset, master 0 wins.
REQ-016 GNTn: the slave request outputs SHALL be a combinational mux of master n's signals, and o_s_cyc SHALL equal i_m_cyc[n].
REQ-017 Stall routing:
- o_m_stall[n] SHALL equal i_s_stall.
- o_m_stall for the non-granted master SHALL be 1.
- In IDLE, both o_m_stall bits SHALL be 1.
REQ-018 o_m_ack[n] and o_m_err[n] SHALL equal i_s_ack and i_s_err only while GNTn; otherwise they SHALL be 0.
REQ-019 Minimum latency: from i_m_cyc rising in IDLE to o_s_stb SHALL be 1 cycle; the arbiter SHALL add no latency to ack, err or data.
REQ-020 SHALL keep a 4-bit outstanding counter:
- +1 on o_s_stb && !i_s_stall.
- -1 on i_s_ack || i_s_err.
- Both in the same cycle: no change.
- Saturate at 15; while saturated, force o_m_stall[n] = 1.
REQ-021 Release: when granted master n drops i_m_cyc:
- The FSM SHALL go to GNT(other) if that master's i_m_cyc is high, else to IDLE.
- The outstanding counter SHALL clear.
REQ-022 If cyc drops with outstanding > 0, the cycle SHALL be aborted: o_s_cyc falls the same cycle, and late slave ack/err SHALL NOT be forwarded to any master.
REQ-023 Grant SHALL never change while i_m_cyc[n] of the granted master is high; no preemption.
REQ-024 Each grant SHALL update the last-granted flag on entry to GNTn.

Reset
REQ-025 On i_resetn low, the following SHALL be asynchronously cleared:
- FSM to IDLE.
- Last-granted flag to 1, so master 0 has priority.
- Outstanding counter and timeout counter to 0.
REQ-026 During reset, o_s_cyc, o_s_stb, o_m_ack and o_m_err SHALL be 0, and o_m_stall SHALL be 2'b11.
REQ-027 Reset mid-transaction SHALL drop o_s_cyc immediately; no response SHALL be forwarded afterwards.

Configuration
REQ-028 With macro WB_ARB_TIMEOUT_EN defined, the block SHALL include an 8-bit watchdog:
- It counts cycles in GNTn with outstanding > 0 and no ack/err.
- It resets on any ack/err or grant change.
- On reaching TIMEOUT, the block SHALL pulse o_m_err[n] for 1 cycle, force o_s_cyc low for that cycle, and clear outstanding.
REQ-029 Without WB_ARB_TIMEOUT_EN, no watchdog logic SHALL exist, and o_m_err SHALL carry only i_s_err.

Structure
REQ-030 The state enum (IDLE/GNT0/GNT1) and the outstanding counter width constant SHALL live in the shared package wb_pkg.
REQ-031 The watchdog SHALL be a sub-module wb_watchdog, instantiated only under WB_ARB_TIMEOUT_EN.

Verification
REQ-032 Single master: master 0 reads 0x10, slave acks after 2 cycles -> o_s_stb 1 cycle after cyc, o_m_ack[0] pulses, o_m_ack[1] stays 0.
REQ-033 Simultaneous requests after reset -> GNT0 first; master 0 drops cyc -> GNT1 on the next edge without passing through IDLE.
REQ-034 Round-robin: 3 back-to-back simultaneous contention rounds -> grants go 0, 1, 0.
REQ-035 Pipelined burst: 4 strobes with 1 stall cycle, then 4 acks -> counter peaks at 4 and returns to 0; grant is held throughout.
REQ-036 Abort: master 1 drops cyc with 2 outstanding -> o_s_cyc falls the same cycle, and the later i_s_ack is not forwarded.
REQ-037 With WB_ARB_TIMEOUT_EN and TIMEOUT=8, the slave never acks -> o_m_err pulses on cycle 8 after the strobe and the counter clears; without the macro, the bus hangs.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Holds the grant state encoding and the outstanding-transfer counter sizing.
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam int OUT_W = 4;
   localparam logic [OUT_W-1:0] OUT_MAX = '1;

endpackage

// File: rtl/wb_watchdog.sv
// Response watchdog for the Wishbone arbiter.
// Counts consecutive cycles in which the granted master is waiting on the
// slave, and fires a single-cycle pulse when the wait reaches TIMEOUT cycles.
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   output logic fire
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] count;

   assign fire = active && (count == LIMIT);

   // Wait-cycle counter: restarts whenever the wait is broken or has fired.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 8'd0;
      end else if (!active || fire) begin
         count <= 8'd0;
      end else begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave pipelined Wishbone arbiter with round-robin priority.
// The grant is registered; the request path to the slave and the response
// path back to the masters are purely combinational, so no latency is added.
// An outstanding counter tracks accepted-but-unanswered strobes; responses
// arriving with nothing outstanding (e.g. after an abort) are swallowed.
// Optional feature: define WB_ARB_TIMEOUT_EN to add a response watchdog.
module wb_arbiter2
   import wb_pkg::*;
#(
   parameter int AW      = 30,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            i_clk,
   input  logic            i_resetn,
   input  logic [1:0]      i_m_cyc,
   input  logic [1:0]      i_m_stb,
   input  logic [1:0]      i_m_we,
   input  logic [2*AW-1:0] i_m_addr,
   input  logic [2*DW-1:0] i_m_data,
   input  logic [7:0]      i_m_sel,
   output logic [1:0]      o_m_ack,
   output logic [1:0]      o_m_stall,
   output logic [1:0]      o_m_err,
   output logic [DW-1:0]   o_m_data,
   output logic            o_s_cyc,
   output logic            o_s_stb,
   output logic            o_s_we,
   output logic [AW-1:0]   o_s_addr,
   output logic [DW-1:0]   o_s_data,
   output logic [3:0]      o_s_sel,
   input  logic            i_s_ack,
   input  logic            i_s_stall,
   input  logic            i_s_err,
   input  logic [DW-1:0]   i_s_data
);

   arb_state_t       state;
   logic             last_gnt;
   logic [OUT_W-1:0] outstanding;

   logic granted;
   logic gidx;
   logic gnt_cyc;
   logic sat;
   logic timeout_fire;
   logic s_cyc;
   logic s_stb;
   logic accept;
   logic resp_ok;
   logic resp_taken;

   assign granted    = (state != IDLE);
   assign gidx       = (state == GNT1);
   assign gnt_cyc    = granted && i_m_cyc[gidx];
   assign sat        = (outstanding == OUT_MAX);
   assign s_cyc      = gnt_cyc && !timeout_fire;
   assign s_stb      = s_cyc && i_m_stb[gidx] && !sat;
   assign accept     = s_stb && !i_s_stall;
   assign resp_ok    = s_cyc && ((outstanding != '0) || accept);
   assign resp_taken = resp_ok && (i_s_ack || i_s_err);

   assign o_m_data   = i_s_data;

`ifdef WB_ARB_TIMEOUT_EN
   logic wd_active;

   assign wd_active = gnt_cyc && (outstanding != '0) && !(i_s_ack || i_s_err);

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (i_clk),
      .rst_n  (i_resetn),
      .active (wd_active),
      .fire   (timeout_fire)
   );
`else
   assign timeout_fire = 1'b0;
`endif

   // Request mux towards the slave and response steering back to the masters.
   always_comb begin
      o_s_cyc   = s_cyc;
      o_s_stb   = s_stb;
      o_s_we    = 1'b0;
      o_s_addr  = '0;
      o_s_data  = '0;
      o_s_sel   = 4'h0;
      o_m_stall = 2'b11;
      o_m_ack   = 2'b00;
      o_m_err   = 2'b00;
      if (granted) begin
         o_s_we          = gidx ? i_m_we[1] : i_m_we[0];
         o_s_addr        = gidx ? i_m_addr[2*AW-1:AW] : i_m_addr[AW-1:0];
         o_s_data        = gidx ? i_m_data[2*DW-1:DW] : i_m_data[DW-1:0];
         o_s_sel         = gidx ? i_m_sel[7:4] : i_m_sel[3:0];
         o_m_stall[gidx] = i_s_stall || sat;
         o_m_ack[gidx]   = resp_ok && i_s_ack;
         o_m_err[gidx]   = (resp_ok && i_s_err) || timeout_fire;
      end
   end

   // Grant FSM, round-robin flag and outstanding-transfer counter.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state       <= IDLE;
         last_gnt    <= 1'b1;
         outstanding <= '0;
      end else begin
         case (state)
            IDLE: begin
               outstanding <= '0;
               if (i_m_cyc[0] && (!i_m_cyc[1] || last_gnt)) begin
                  state    <= GNT0;
                  last_gnt <= 1'b0;
               end else if (i_m_cyc[1]) begin
                  state    <= GNT1;
                  last_gnt <= 1'b1;
               end
            end
            GNT0, GNT1: begin
               if (!i_m_cyc[gidx]) begin
                  outstanding <= '0;
                  if (i_m_cyc[~gidx]) begin
                     state    <= gidx ? GNT0 : GNT1;
                     last_gnt <= ~gidx;
                  end else begin
                     state <= IDLE;
                  end
               end else if (timeout_fire) begin
                  outstanding <= '0;
               end else if (accept && !resp_taken) begin
                  outstanding <= outstanding + OUT_W'(1);
               end else if (resp_taken && !accept) begin
                  outstanding <= outstanding - OUT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios followed by a
// randomized phase, all checked cycle by cycle against a transaction-level
// model of grant ownership, priority and outstanding transfers.
// Define WB_ARB_TIMEOUT_EN to exercise the watchdog with TIMEOUT=8.
module tb_wb_arbiter2;

   localparam int AW = 30;
   localparam int DW = 32;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   logic            clk = 1'b0;
   logic            resetn;
   logic [1:0]      m_cyc, m_stb, m_we;
   logic [2*AW-1:0] m_addr;
   logic [2*DW-1:0] m_data;
   logic [7:0]      m_sel;
   logic [1:0]      m_ack, m_stall, m_err;
   logic [DW-1:0]   m_rdata;
   logic            s_cyc, s_stb, s_we;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_wdata;
   logic [3:0]      s_sel;
   logic            s_ack, s_stall, s_err;
   logic [DW-1:0]   s_rdata;

   int checks = 0;
   int failures = 0;

   // Reference model: who owns the bus, who was granted last, how many
   // transfers the owner has in flight, and how long it has waited.
   int owner = -1;
   int last_g = 1;
   int pend = 0;
   int wd = 0;

   // Random-phase traffic generator state.
   int left[2];
   int issued[2];
   int resp[2];
   bit act[2];
   bit err_seen[2];
   int spend = 0;

   always #5 clk = ~clk;

   wb_arbiter2 #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .i_clk     (clk),
      .i_resetn  (resetn),
      .i_m_cyc   (m_cyc),
      .i_m_stb   (m_stb),
      .i_m_we    (m_we),
      .i_m_addr  (m_addr),
      .i_m_data  (m_data),
      .i_m_sel   (m_sel),
      .o_m_ack   (m_ack),
      .o_m_stall (m_stall),
      .o_m_err   (m_err),
      .o_m_data  (m_rdata),
      .o_s_cyc   (s_cyc),
      .o_s_stb   (s_stb),
      .o_s_we    (s_we),
      .o_s_addr  (s_addr),
      .o_s_data  (s_wdata),
      .o_s_sel   (s_sel),
      .i_s_ack   (s_ack),
      .i_s_stall (s_stall),
      .i_s_err   (s_err),
      .i_s_data  (s_rdata)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Compare DUT outputs at the falling edge, then advance the model.
   task automatic checkStep();
      logic       e_cyc, e_stb;
      logic [1:0] e_stall, e_ack, e_err;
      bit         full, acc, has, fire, rsp;
      int         winner;
      @(negedge clk);
      if (!resetn) begin
         checkOutput("rst_s_cyc", s_cyc, 1'b0);
         checkOutput("rst_s_stb", s_stb, 1'b0);
         checkOutput("rst_m_ack", m_ack, 2'b00);
         checkOutput("rst_m_err", m_err, 2'b00);
         checkOutput("rst_m_stall", m_stall, 2'b11);
         owner  = -1;
         last_g = 1;
         pend   = 0;
         wd     = 0;
         return;
      end
      e_cyc = 1'b0; e_stb = 1'b0; e_stall = 2'b11; e_ack = 2'b00; e_err = 2'b00;
      full = 0; acc = 0; has = 0; fire = 0;
      if (owner >= 0) begin
         full = (pend == 15);
`ifdef WB_ARB_TIMEOUT_EN
         fire = m_cyc[owner] && (pend > 0) && !(s_ack || s_err) && (wd == TB_TIMEOUT - 1);
`endif
         e_cyc          = m_cyc[owner] && !fire;
         e_stb          = e_cyc && m_stb[owner] && !full;
         e_stall[owner] = s_stall || full;
         acc            = e_stb && !s_stall;
         has            = e_cyc && ((pend > 0) || acc);
         e_ack[owner]   = has && s_ack;
         e_err[owner]   = (has && s_err) || fire;
      end
      checkOutput("s_cyc", s_cyc, e_cyc);
      checkOutput("s_stb", s_stb, e_stb);
      checkOutput("m_stall", m_stall, e_stall);
      checkOutput("m_ack", m_ack, e_ack);
      checkOutput("m_err", m_err, e_err);
      checkOutput("m_rdata", m_rdata, s_rdata);
      if (e_cyc) begin
         checkOutput("s_addr", s_addr, m_addr[owner*AW +: AW]);
         checkOutput("s_wdata", s_wdata, m_data[owner*DW +: DW]);
         checkOutput("s_we", s_we, m_we[owner]);
         checkOutput("s_sel", s_sel, m_sel[owner*4 +: 4]);
      end
      if (owner < 0) begin
         pend = 0;
         wd   = 0;
         if (m_cyc != 2'b00) begin
            if (m_cyc == 2'b11) winner = (last_g == 1) ? 0 : 1;
            else winner = m_cyc[0] ? 0 : 1;
            owner  = winner;
            last_g = winner;
         end
      end else if (!m_cyc[owner]) begin
         pend = 0;
         wd   = 0;
         if (m_cyc[1-owner]) begin
            owner  = 1 - owner;
            last_g = owner;
         end else begin
            owner = -1;
         end
      end else if (fire) begin
         pend = 0;
         wd   = 0;
      end else begin
         rsp = has && (s_ack || s_err);
         if (pend > 0 && !(s_ack || s_err)) wd++;
         else wd = 0;
         pend = pend + int'(acc) - int'(rsp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         checkStep();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic setM(input int n, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
      m_cyc[n]            = cyc;
      m_stb[n]            = stb;
      m_we[n]             = we;
      m_addr[n*AW +: AW]  = addr;
      m_data[n*DW +: DW]  = data;
      m_sel[n*4 +: 4]     = 4'hF;
   endtask

   task automatic setS(input bit ack, input bit err, input bit stall);
      s_ack   = ack;
      s_err   = err;
      s_stall = stall;
      s_rdata = $urandom;
   endtask

   // Drive one cycle of random master and slave traffic.
   task automatic applyStimulus();
      for (int n = 0; n < 2; n++) begin
         if (!act[n]) begin
            if ($urandom_range(7) == 0) begin
               act[n]      = 1;
               left[n]     = ($urandom_range(9) == 0) ? $urandom_range(20, 12) : $urandom_range(6, 1);
               issued[n]   = 0;
               resp[n]     = 0;
               err_seen[n] = 0;
            end
         end else if (err_seen[n] || $urandom_range(63) == 0 || (left[n] == 0 && resp[n] >= issued[n])) begin
            act[n] = 0;
         end
         m_cyc[n]           = act[n];
         m_stb[n]           = act[n] && (left[n] > 0) && ($urandom_range(3) != 0);
         m_we[n]            = 1'($urandom);
         m_addr[n*AW +: AW] = AW'($urandom);
         m_data[n*DW +: DW] = $urandom;
         m_sel[n*4 +: 4]    = 4'($urandom);
      end
      s_stall = ($urandom_range(3) == 0);
      s_ack   = 1'b0;
      s_err   = 1'b0;
      if (spend > 0 && $urandom_range(4) < 2) begin
         if ($urandom_range(9) == 0) s_err = 1'b1;
         else s_ack = 1'b1;
         spend--;
      end
      s_rdata = $urandom;
   endtask

   // Let the random masters and slave react to what the arbiter did.
   task automatic observe();
      for (int n = 0; n < 2; n++) begin
         if (m_cyc[n] && m_stb[n] && !m_stall[n]) begin
            left[n]--;
            issued[n]++;
         end
         if (m_ack[n]) resp[n]++;
         if (m_err[n]) err_seen[n] = 1;
      end
      if (!s_cyc) spend = 0;
      else if (s_stb && !s_stall) spend++;
   endtask

   initial begin
      int done;
      bit stalled;
      resetn = 1'b0;
      m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_data = '0; m_sel = '0;
      setS(1, 1, 0);
      setM(0, 1, 1, 0, 30'h1, 32'h11);
      setM(1, 1, 1, 1, 30'h2, 32'h22);
      #1;
      tick(3);
      m_cyc = '0; m_stb = '0;
      setS(0, 0, 0);
      resetn = 1'b1;
      tick(1);

      $display("[TB] simultaneous request after reset");
      setM(0, 1, 1, 0, 30'h100, 32'hA0);
      setM(1, 1, 1, 1, 30'h200, 32'hB0);
      tick(2);
      setM(0, 1, 0, 0, 30'h100, 32'hA0);
      setS(1, 0, 0); tick(1);
      setS(0, 0, 0);
      setM(0, 0, 0, 0, 30'h0, 32'h0);
      tick(2);
      setM(1, 1, 0, 1, 30'h200, 32'hB0);
      setS(1, 0, 0); tick(1);
      setS(0, 0, 0);
      setM(1, 0, 0, 0, 30'h0, 32'h0);
      tick(2);

      $display("[TB] single master read");
      setM(0, 1, 1, 0, 30'h10, 32'h0);
      tick(2);
      setM(0, 1, 0, 0, 30'h10, 32'h0);
      tick(1);
      setS(1, 0, 0); tick(1);
      setS(0, 0, 0);
      setM(0, 0, 0, 0, 30'h0, 32'h0);
      tick(2);

      $display("[TB] round robin");
      resetn = 1'b0; tick(1); resetn = 1'b1; tick(1);
      for (int r = 0; r < 3; r++) begin
         setM(0, 1, 1, 0, 30'h300 + 30'(r), 32'hC0);
         setM(1, 1, 1, 0, 30'h400 + 30'(r), 32'hD0);
         tick(2);
         m_stb = 2'b00;
         setS(1, 0, 0); tick(1);
         setS(0, 0, 0);
         m_cyc = 2'b00;
         tick(2);
      end

      $display("[TB] pipelined burst");
      setM(0, 1, 0, 1, 30'h500, 32'h0);
      tick(1);
      done = 0;
      stalled = 0;
      while (done < 4) begin
         setM(0, 1, 1, 1, 30'h500 + 30'(done), 32'h50 + 32'(done));
         setS(0, 0, (done == 1) && !stalled);
         if (done == 1 && !stalled) stalled = 1;
         else done++;
         tick(1);
      end
      setM(0, 1, 0, 1, 30'h500, 32'h0);
      setS(1, 0, 0); tick(4);
      setS(0, 0, 0); tick(1);
      setM(0, 0, 0, 0, 30'h0, 32'h0);
      tick(2);

      $display("[TB] abort with outstanding transfers");
      setM(1, 1, 1, 0, 30'h600, 32'h0);
      tick(3);
      setM(1, 0, 0, 0, 30'h0, 32'h0);
      setM(0, 1, 0, 0, 30'h700, 32'h0);
      tick(1);
      setS(1, 0, 0); tick(2);
      setS(0, 0, 0);
      setM(0, 1, 1, 0, 30'h700, 32'h0); tick(1);
      setM(0, 1, 0, 0, 30'h700, 32'h0);
      setS(1, 0, 0); tick(1);
      setS(0, 0, 0);
      setM(0, 0, 0, 0, 30'h0, 32'h0);
      tick(2);

      $display("[TB] outstanding saturation");
      setM(0, 1, 1, 1, 30'h800, 32'h0);
      tick(19);
      setM(0, 1, 0, 1, 30'h800, 32'h0);
      setS(1, 0, 0); tick(15);
      setS(0, 0, 0);
      setM(0, 0, 0, 0, 30'h0, 32'h0);
      tick(2);

      $display("[TB] unanswered strobe");
      setM(1, 1, 1, 0, 30'h900, 32'h0);
      tick(2);
      setM(1, 1, 0, 0, 30'h900, 32'h0);
      tick(12);
      setM(1, 0, 0, 0, 30'h0, 32'h0);
      tick(2);

      $display("[TB] reset mid-transaction");
      setM(0, 1, 1, 0, 30'hA00, 32'h0);
      tick(2);
      setM(0, 1, 0, 0, 30'hA00, 32'h0);
      resetn = 1'b0;
      setS(1, 0, 0); tick(2);
      resetn = 1'b1;
      tick(1);
      setS(0, 0, 0);
      setM(0, 0, 0, 0, 30'h0, 32'h0);
      tick(2);

      $display("[TB] random traffic");
      for (int n = 0; n < 2; n++) begin
         act[n] = 0; left[n] = 0; issued[n] = 0; resp[n] = 0; err_seen[n] = 0;
      end
      spend = 0;
      for (int c = 0; c < 3000; c++) begin
         applyStimulus();
         checkStep();
         observe();
         @(posedge clk);
         #1;
      end
      m_cyc = 2'b00; m_stb = 2'b00;
      setS(0, 0, 0);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
